// File: rtl/fp_sub_pkg.sv
// rtl/fp_sub_pkg.sv - shared widths, constants, FSM states and operand classes for fp_subtractor_seq
package fp_sub_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int EXT_W  = 28;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    // Classify one IEEE-754 single-precision word.
    function automatic op_class_t classify(input logic [31:0] w);
        if (w[30:23] == 8'hFF) begin
            return (w[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (w[30:23] == 8'h00) begin
            return (w[22:0] != 23'd0) ? CLS_SUB : CLS_ZERO;
        end else begin
            return CLS_NORMAL;
        end
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - field split, operand classification and magnitude swap
module fp_unpack
    import fp_sub_pkg::*;
(
    input  logic [31:0]      x_word,
    input  logic [31:0]      y_word,
    output op_class_t        x_cls,
    output op_class_t        y_cls,
    output logic             l_sign,
    output logic             s_sign,
    output logic [EXP_W-1:0] l_exp,
    output logic [MANT_W:0]  l_mant,
    output logic [MANT_W:0]  s_mant,
    output logic [4:0]       diff
);

    logic             x_ge;
    logic [31:0]      l_word;
    logic [31:0]      s_word;
    logic [EXP_W-1:0] s_exp;
    logic [EXP_W-1:0] diff_full;

    // Put the larger magnitude in the "l" slot; subnormals/zeros use exponent 1 with no hidden bit.
    always_comb begin
        x_cls     = classify(x_word);
        y_cls     = classify(y_word);
        x_ge      = (x_word[30:0] >= y_word[30:0]);
        l_word    = x_ge ? x_word : y_word;
        s_word    = x_ge ? y_word : x_word;
        l_sign    = l_word[31];
        s_sign    = s_word[31];
        l_exp     = (l_word[30:23] == 8'h00) ? 8'd1 : l_word[30:23];
        s_exp     = (s_word[30:23] == 8'h00) ? 8'd1 : s_word[30:23];
        l_mant    = {(l_word[30:23] != 8'h00), l_word[22:0]};
        s_mant    = {(s_word[30:23] != 8'h00), s_word[22:0]};
        diff_full = l_exp - s_exp;
        diff      = (diff_full > 8'd27) ? 5'd27 : diff_full[4:0];
    end

endmodule

// File: rtl/fp_subtractor_seq.sv
// rtl/fp_subtractor_seq.sv - multi-cycle IEEE-754 single subtractor x - y; FP_SUB_RNE_ROUND_EN selects round-to-nearest-even
module fp_subtractor_seq
    import fp_sub_pkg::*;
#(
    parameter int ALIGN_STEP = 8,
    parameter int NORM_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        busy
);

    localparam logic [4:0] A_STEP = 5'(ALIGN_STEP);

    state_t           state;
    logic [31:0]      x_r;
    logic [31:0]      ny_r;
    logic             sign_r;
    logic             eff_sub;
    logic [9:0]       exp_r;
    logic [EXT_W-1:0] a_m;
    logic [EXT_W-1:0] b_m;
    logic [4:0]       d_r;

    op_class_t        x_cls;
    op_class_t        y_cls;
    logic             l_sign;
    logic             s_sign;
    logic [EXP_W-1:0] l_exp;
    logic [MANT_W:0]  l_mant;
    logic [MANT_W:0]  s_mant;
    logic [4:0]       diff;

    logic [4:0]       align_sh;
    logic [EXT_W-1:0] align_mask;
    logic [EXT_W-1:0] align_b;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] norm_m;
    logic [9:0]       norm_e;
    logic             rnd_up;
    logic [24:0]      rnd_sum;
    logic [9:0]       rnd_e;
    logic [22:0]      rnd_frac;
    logic             rnd_hid;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    fp_unpack u_unpack (
        .x_word (x_r),
        .y_word (ny_r),
        .x_cls  (x_cls),
        .y_cls  (y_cls),
        .l_sign (l_sign),
        .s_sign (s_sign),
        .l_exp  (l_exp),
        .l_mant (l_mant),
        .s_mant (s_mant),
        .diff   (diff)
    );

    // One alignment step: shift B right, folding every lost bit into the sticky bit.
    always_comb begin
        align_sh   = (d_r > A_STEP) ? A_STEP : d_r;
        align_mask = (28'd1 << align_sh) - 28'd1;
        align_b    = (b_m >> align_sh) | {27'd0, |(b_m & align_mask)};
    end

    // Magnitude add, or A - B when effective signs differ (A is never smaller than B).
    always_comb begin
        sum = eff_sub ? (a_m - b_m) : (a_m + b_m);
    end

    // One left-normalisation step of up to NORM_STEP bits, never taking the exponent below 1.
    always_comb begin
        norm_m = a_m;
        norm_e = exp_r;
        for (int i = 0; i < NORM_STEP; i++) begin
            if (!norm_m[26] && (norm_e > 10'd1)) begin
                norm_m = norm_m << 1;
                norm_e = norm_e - 10'd1;
            end
        end
    end

`ifdef FP_SUB_RNE_ROUND_EN
    assign rnd_up = a_m[2] & (a_m[1] | a_m[0] | a_m[3]);
`else
    assign rnd_up = 1'b0;
`endif

    // Apply the rounding increment and renormalise if the mantissa carries out.
    always_comb begin
        rnd_sum  = {1'b0, a_m[26:3]} + {24'd0, rnd_up};
        rnd_e    = rnd_sum[24] ? (exp_r + 10'd1) : exp_r;
        rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
        rnd_hid  = rnd_sum[24] | rnd_sum[23];
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            x_r       <= 32'd0;
            ny_r      <= 32'd0;
            sign_r    <= 1'b0;
            eff_sub   <= 1'b0;
            exp_r     <= 10'd0;
            a_m       <= '0;
            b_m       <= '0;
            d_r       <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r   <= x;
                        ny_r  <= {~y[31], y[30:0]};
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (x_cls == CLS_NAN || y_cls == CLS_NAN ||
                        (x_cls == CLS_INF && y_cls == CLS_INF && x_r[31] != ny_r[31])) begin
                        result    <= QNAN;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (x_cls == CLS_INF || y_cls == CLS_INF) begin
                        result    <= {l_sign, 8'hFF, 23'd0};
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        sign_r  <= l_sign;
                        eff_sub <= l_sign ^ s_sign;
                        exp_r   <= {2'b00, l_exp};
                        a_m     <= {1'b0, l_mant, 3'b000};
                        b_m     <= {1'b0, s_mant, 3'b000};
                        d_r     <= diff;
                        state   <= (diff != 5'd0) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    b_m <= align_b;
                    d_r <= d_r - align_sh;
                    if (d_r == align_sh) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    a_m <= sum;
                    if (sum == '0) begin
                        sign_r <= 1'b0;
                        state  <= S_ROUND;
                    end else if (sum[27] || (!sum[26] && exp_r > 10'd1)) begin
                        state <= S_NORM;
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_NORM: begin
                    if (a_m[27]) begin
                        a_m   <= {1'b0, a_m[27:2], a_m[1] | a_m[0]};
                        exp_r <= exp_r + 10'd1;
                        state <= S_ROUND;
                    end else begin
                        a_m   <= norm_m;
                        exp_r <= norm_e;
                        if (norm_m[26] || norm_e == 10'd1) begin
                            state <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    if (rnd_e >= 10'd255) begin
                        result   <= {sign_r, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else begin
                        result   <= {sign_r, (rnd_hid ? rnd_e[7:0] : 8'h00), rnd_frac};
                        overflow <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb/tb_fp_subtractor_seq.sv - scoreboard bench for fp_subtractor_seq with directed vectors
module tb_fp_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          hold;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    fp_subtractor_seq #(.ALIGN_STEP(8), .NORM_STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic eo, input int lat, input int hold);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout x=%h y=%h in_ready=%b required=1", a, b, in_ready);
            return;
        end
        x = a;
        y = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.res  = er;
        e.ovf  = eo;
        e.lat  = lat;
        e.hold = hold;
        e.acc  = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout pending=%0d in_ready=%b required pending=0", exp_q.size(), in_ready);
        end
    endtask

    // Monitor: pop the expectation when a result appears, then hold out_ready low for the requested cycles.
    initial begin : monitor
        exp_t        cur;
        logic        seen;
        int          held;
        logic [31:0] held_res;
        seen = 1'b0;
        held = 0;
        held_res = 32'd0;
        cur.hold = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = 0;
                    held_res = result;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output result=%h required no output", result);
                        cur.hold = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("result", result, cur.res);
                        chk("overflow", {31'd0, overflow}, {31'd0, cur.ovf});
                        chk("latency", cyc - cur.acc + 1, cur.lat);
                    end
                end else begin
                    chk("hold_result", result, held_res);
                    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (held >= cur.hold) begin
                    out_ready = 1'b1;
                end else begin
                    held++;
                end
            end else begin
                seen = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", result, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        send(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 5, 0);
        send(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 4, 0);
        send(32'h3F800000, 32'h3F800001, 32'hB4000000, 1'b0, 27, 0);
        // in_valid while busy must be ignored
        @(negedge clk);
        x = 32'h12345678;
        y = 32'h0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        send(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 5, 0);
        send(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 2, 0);
`ifdef FP_SUB_RNE_ROUND_EN
        send(32'h3F800000, 32'hB3C00000, 32'h3F800001, 1'b0, 7, 0);
`else
        send(32'h3F800000, 32'hB3C00000, 32'h3F800000, 1'b0, 7, 0);
`endif
        send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 2, 0);
        send(32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b0, 2, 0);
        send(32'h00000002, 32'h00000001, 32'h00000001, 1'b0, 4, 0);
        send(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 5, 5);
        wait_idle();

        // Reset while aligning discards the operation.
        @(negedge clk);
        x = 32'h3F800000;
        y = 32'hB3C00000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_output", {31'd0, out_valid}, 32'd0);

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
